// File: rtl/mem_config_pkg.sv
// rtl/mem_config_pkg.sv - shared memory geometry for the Sobel image memories
package mem_config_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 16;
endpackage

// File: rtl/sobel_config_pkg.sv
// rtl/sobel_config_pkg.sv - Sobel image geometry and output-streamer state type
package sobel_config_pkg;
  localparam int IMG_WIDTH          = 64;
  localparam int IMG_HEIGHT         = 64;
  localparam int DEFAULT_NUM_PIXELS = IMG_WIDTH * IMG_HEIGHT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } stream_state_e;
endpackage

// File: rtl/sobel_stream_fifo2.sv
// rtl/sobel_stream_fifo2.sv - two-entry pixel buffer with last tag and same-cycle push/pop
module sobel_stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_last_o
);
  logic [1:0][WIDTH-1:0] data_q;
  logic [1:0]            last_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;
  logic                  pop_ok;

  // A pop on an empty buffer is ignored so the head pointer never runs ahead.
  assign pop_ok      = pop_i && (count_q != 2'd0);
  assign count_o     = count_q;
  assign empty_o     = (count_q == 2'd0);
  assign head_data_o = data_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];

  // Storage, pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q   <= '0;
      last_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_ok})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // The issuer's credit rule must never let a push land on a full buffer.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_ok && (count_q == 2'd2)));
endmodule

// File: rtl/sobel_out_streamer.sv
// rtl/sobel_out_streamer.sv - streams the Sobel output memory as valid/ready pixels
module sobel_out_streamer
  import sobel_config_pkg::*;
#(
  parameter int DATA_WIDTH = mem_config_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mem_config_pkg::ADDR_WIDTH,
  parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  finish_i,
  output logic                  rd_en_omem_o,
  output logic [ADDR_WIDTH-1:0] addr_omem_o,
  input  logic [DATA_WIDTH-1:0] data_omem_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam logic [ADDR_WIDTH:0]   OUT_TOTAL = (ADDR_WIDTH + 1)'(NUM_PIXELS);

  stream_state_e         state_q;
  logic                  finish_q;
  logic [ADDR_WIDTH-1:0] issue_addr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [ADDR_WIDTH:0]   out_cnt_q;
  logic [ADDR_WIDTH:0]   out_cnt_d;
  logic                  rd_en_q;
  logic                  busy_q;
  logic                  done_q;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  trigger;
  logic                  handshake;
  logic                  issue;
  logic [1:0]            credit_used;

  assign trigger   = finish_i & ~finish_q;
  assign m_valid_o = ~fifo_empty;
  assign handshake = m_valid_o & m_ready_i;

  // Slots already spoken for after this cycle's pop; counting the pop lets a
  // read go out every cycle while the consumer keeps ready high.
  assign credit_used = fifo_count + {1'b0, inflight_q} - {1'b0, handshake};
  assign issue       = (state_q == ST_STREAM) && (credit_used < 2'd2);
  assign out_cnt_d   = out_cnt_q + (ADDR_WIDTH + 1)'(handshake);

  // The memory samples the address in the issue cycle; otherwise hold the last one.
  assign addr_omem_o  = issue ? issue_addr_q : addr_q;
  assign rd_en_omem_o = rd_en_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  // Control FSM, issue counter, in-flight tracking and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      finish_q        <= finish_i;
      issue_addr_q    <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      out_cnt_q       <= '0;
      rd_en_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      finish_q        <= finish_i;
      inflight_q      <= issue;
      inflight_last_q <= issue && (issue_addr_q == LAST_ADDR);
      out_cnt_q       <= out_cnt_d;
      done_q          <= 1'b0;
      if (issue) begin
        addr_q <= issue_addr_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q      <= ST_STREAM;
            issue_addr_q <= '0;
            out_cnt_q    <= '0;
            rd_en_q      <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (issue) begin
            if (issue_addr_q == LAST_ADDR) begin
              state_q <= ST_DRAIN;
            end else begin
              issue_addr_q <= issue_addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (!inflight_q && (out_cnt_d == OUT_TOTAL)) begin
            state_q <= ST_DONE;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  sobel_stream_fifo2 #(
    .WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (inflight_q),
    .push_data_i(data_omem_i),
    .push_last_i(inflight_last_q),
    .pop_i      (handshake),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .head_data_o(m_data_o),
    .head_last_o(m_last_o)
  );
endmodule

// File: tb/tb_sobel_out_streamer.sv
// tb/tb_sobel_out_streamer.sv - scoreboard bench for the Sobel output streamer
module tb_sobel_out_streamer;
  logic        clk;
  logic        rst_i;
  logic        finish_i;
  logic        rd_en_omem_o;
  logic [15:0] addr_omem_o;
  logic [7:0]  data_omem_i;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [7:0]  m_data_o;
  logic        m_last_o;
  logic        busy_o;
  logic        done_o;

  int vectors;
  int errors;
  int hs_cnt;
  int done_cnt;

  logic [8:0] exp_q[$];
  logic [7:0] mem [4];

  logic       prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  sobel_out_streamer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(16),
    .NUM_PIXELS(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .finish_i    (finish_i),
    .rd_en_omem_o(rd_en_omem_o),
    .addr_omem_o (addr_omem_o),
    .data_omem_i (data_omem_i),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_data_o    (m_data_o),
    .m_last_o    (m_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read output memory, one cycle latency
  always @(posedge clk) begin
    if (addr_omem_o < 16'd4) data_omem_i <= mem[addr_omem_o[1:0]];
    else                     data_omem_i <= 8'hEE;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_image();
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b0, 8'h30});
    exp_q.push_back({1'b1, 8'h40});
  endtask

  task automatic wait_done(input int mode, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (mode == 1) m_ready_i = ((i % 4) == 0) || ((i % 4) == 3);
      else           m_ready_i = 1'b1;
      tick();
      if (done_o) seen = 1'b1;
    end
    m_ready_i = 1'b1;
    if (!seen) begin
      vectors++;
      errors++;
      $display("FAIL done_timeout: no done_o within %0d cycles", bound);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, rd_en_omem_o, 0);
    chk({tag, "_addr"},  addr_omem_o, 0);
    chk({tag, "_valid"}, m_valid_o, 0);
    chk({tag, "_data"},  m_data_o, 0);
    chk({tag, "_last"},  m_last_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
  endtask

  // monitor: pops the scoreboard on every handshake, checks stall stability and address range
  always @(negedge clk) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (m_valid_o && prev_stall) begin
        chk("stall_data", m_data_o, prev_data);
        chk("stall_last", m_last_o, prev_last);
      end
      if (rd_en_omem_o) chk("addr_range", (addr_omem_o <= 16'd3), 1);
      if (m_valid_o && m_ready_i) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_pixel: got data %0h with no pixel expected", m_data_o);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          chk("pixel_data", m_data_o, e[7:0]);
          chk("pixel_last", m_last_o, e[8]);
        end
      end
      if (done_o) done_cnt++;
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
    end
  end

  initial begin
    int h0;
    int d0;
    bit got2;
    vectors = 0; errors = 0; hs_cnt = 0; done_cnt = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30; mem[3] = 8'h40;
    rst_i = 1'b1; finish_i = 1'b0; m_ready_i = 1'b1;
    tick(); tick(); tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick(); tick();

    // basic timing: trigger edge is cycle 0
    push_image();
    h0 = hs_cnt;
    finish_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t1_rd_en_c%0d", k), rd_en_omem_o, (k >= 1 && k <= 6));
      chk($sformatf("t1_valid_c%0d", k), m_valid_o, (k >= 3 && k <= 6));
      chk($sformatf("t1_last_c%0d", k),  m_valid_o && m_last_o, (k == 6));
      chk($sformatf("t1_done_c%0d", k),  done_o, (k == 7));
      chk($sformatf("t1_busy_c%0d", k),  busy_o, (k >= 1 && k <= 6));
    end
    chk("t1_hs_count", hs_cnt - h0, 4);

    // idle with finish low
    finish_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("idle_rd_en", rd_en_omem_o, 0);
      chk("idle_valid", m_valid_o, 0);
    end

    // toggling ready
    push_image();
    h0 = hs_cnt; d0 = done_cnt;
    finish_i = 1'b1;
    wait_done(1, 80);
    tick();
    chk("t2_hs_count", hs_cnt - h0, 4);
    chk("t2_done_count", done_cnt - d0, 1);
    chk("t2_sb_empty", exp_q.size(), 0);

    // finish re-pulsed mid-stream
    finish_i = 1'b0; tick(); tick();
    push_image();
    h0 = hs_cnt; d0 = done_cnt;
    finish_i = 1'b1; tick(); tick();
    finish_i = 1'b0; tick();
    finish_i = 1'b1; tick();
    finish_i = 1'b0;
    wait_done(0, 40);
    for (int k = 0; k < 10; k++) tick();
    chk("t4_hs_count", hs_cnt - h0, 4);
    chk("t4_done_count", done_cnt - d0, 1);
    chk("t4_sb_empty", exp_q.size(), 0);

    // reset after the second handshake, then restart
    push_image();
    h0 = hs_cnt;
    finish_i = 1'b1;
    got2 = 1'b0;
    for (int k = 0; k < 20 && !got2; k++) begin
      @(negedge clk); #1;
      if (hs_cnt - h0 >= 2) got2 = 1'b1;
    end
    chk("t5_two_handshakes", got2, 1);
    rst_i = 1'b1;
    tick();
    check_all_zero("t5_after_reset");
    exp_q.delete();
    rst_i = 1'b0;
    tick(); tick();
    chk("t5_no_retrigger", rd_en_omem_o, 0);
    finish_i = 1'b0; tick();
    push_image();
    h0 = hs_cnt; d0 = done_cnt;
    finish_i = 1'b1;
    wait_done(0, 40);
    tick();
    chk("t5_hs_count", hs_cnt - h0, 4);
    chk("t5_done_count", done_cnt - d0, 1);

    // finish already high across reset release
    rst_i = 1'b1; finish_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t6_no_trigger", busy_o, 0);
    end
    finish_i = 1'b0; tick();
    push_image();
    h0 = hs_cnt;
    finish_i = 1'b1;
    wait_done(0, 40);
    tick();
    chk("t6_hs_count", hs_cnt - h0, 4);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/sobel_out_streamer.md
Name: sobel_out_streamer

Overview:
- Downstream consumer of the Sobel top level.
- Once the Sobel execution unit reports completion, reads the output-image memory sequentially through its external read port (read enable, address, data).
- Emits the pixels as a valid/ready stream with a last-pixel marker.
- Hides the one-cycle synchronous read latency of the output memory behind a 2-entry buffer, so the stream sustains one pixel per cycle under continuous ready.

Parameters:
- DATA_WIDTH, 8, pixel width; taken from mem_config_pkg.
- ADDR_WIDTH, 16, output-memory address width; taken from mem_config_pkg.
- NUM_PIXELS, 4096, number of output pixels to stream; addresses 0..NUM_PIXELS-1.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- finish_i  in  1  completion level from the Sobel top level.
- rd_en_omem_o  in/out: out  1  output-memory read-mode select; high selects the external address and blocks Sobel writes.
- addr_omem_o  out  ADDR_WIDTH  output-memory read address.
- data_omem_i  in  DATA_WIDTH  output-memory read data; valid 1 cycle after the address is presented.
- m_valid_o  out  1  stream pixel valid.
- m_ready_i  in  1  stream consumer ready.
- m_data_o  out  DATA_WIDTH  stream pixel.
- m_last_o  out  1  high with the pixel at address NUM_PIXELS-1.
- busy_o  out  1  high from trigger until the last handshake.
- done_o  out  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State goes to IDLE.
  - All outputs 0, addresses 0, buffer emptied, in-flight read discarded.
  - finish_i edge detector is loaded with the current finish_i, so a level already high does not retrigger.
- Trigger: a rising edge of finish_i (finish_i=1, registered previous value=0) while in IDLE.
  - A rising edge in any other state is ignored.
- States:
  - IDLE: rd_en_omem_o=0, busy_o=0. On trigger -> STREAM; issue address resets to 0.
  - STREAM: rd_en_omem_o=1, busy_o=1.
    - A read is issued in a cycle when (buffer count + read in flight) < 2.
    - Issue means: addr_omem_o holds the issue address this cycle, the in-flight flag is set for next cycle, and the issue address increments.
    - Otherwise addr_omem_o holds its value and no read is flagged.
    - When address NUM_PIXELS-1 has been issued -> DRAIN.
  - DRAIN: rd_en_omem_o=1, busy_o=1, no new issues. When the buffer is empty, nothing is in flight and the last handshake has occurred -> DONE.
  - DONE: done_o=1 for exactly this cycle, rd_en_omem_o=0, busy_o=0. Next cycle -> IDLE.
- Read return:
  - The cycle after an issue, data_omem_i is pushed into the buffer.
  - The credit rule guarantees the push never overflows; overflow is an assertion failure.
- Stream interface:
  - m_valid_o = buffer not empty. m_data_o = buffer head.
  - Handshake occurs when m_valid_o and m_ready_i; the handshake pops the head.
  - A push and a pop in the same cycle are both honoured; count unchanged.
  - While m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable.
- m_last_o: each buffer entry carries a last tag, set when its address equals NUM_PIXELS-1.
- Latency and throughput:
  - First m_valid_o is 3 cycles after the trigger edge: edge detect, issue, capture.
  - Steady-state throughput is 1 pixel/cycle with m_ready_i held high.
- Counter widths:
  - The issue counter is ADDR_WIDTH wide and never wraps; it stops at NUM_PIXELS-1.
  - An output counter of ADDR_WIDTH+1 bits tracks handshakes for the DRAIN exit.
- NUM_PIXELS=1: single issue, immediate DRAIN; that pixel has m_last_o=1.
- finish_i falling mid-stream: no effect; streaming completes.

Decomposition:
- sobel_config_pkg gains:
  - the NUM_PIXELS default derived from image width and height;
  - the streamer state enum type (IDLE, STREAM, DRAIN, DONE).
- DATA_WIDTH and ADDR_WIDTH come from mem_config_pkg.
- One sub-module: sobel_stream_fifo2, a 2-entry buffer with push/pop, count, a data+last payload and same-cycle push/pop support.

Test Plan:
- NUM_PIXELS=4, memory holds 0x10,0x20,0x30,0x40, m_ready_i=1, finish_i rising at cycle 0 -> m_valid_o cycles 3..6 with data 0x10..0x40; m_last_o only at cycle 6; done_o pulse at cycle 7; rd_en_omem_o high cycles 1..6.
- Same image, m_ready_i toggling 1,0,0,1,... -> exactly 4 handshakes in address order, no duplicates; data stable while stalled; addr_omem_o never exceeds 3.
- Idle check with finish_i=0 for 20 cycles -> rd_en_omem_o=0 and m_valid_o=0 throughout.
- finish_i pulsed again mid-stream -> no restart; exactly NUM_PIXELS pixels and one done_o pulse.
- rst_i asserted after the 2nd handshake -> next cycle: all outputs 0, state IDLE. A new finish_i edge restarts the stream from address 0.
- finish_i already high when rst_i is released -> no trigger until finish_i falls and rises again.
